sram_loader_4096x32: RTL and testbench

- Write-side initiator for the 4096x32 single-port SRAM macro wrapper.
- Accepts a valid/ready stream of 32-bit words and writes them to consecutive SRAM addresses starting at BASE_ADDR.
- Optionally reads the region back and checks a 32-bit additive checksum.
- Used to load weight/instruction images into the SRAM that is read-only in normal operation. This block is the writer end of the port.

---
 rtl/sram_loader_4096x32.sv | 202 ++++++++++++++++++++
 tb/tb_sram_loader_4096x32.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_loader_4096x32.sv
// Writer end of the 4096x32 single-port SRAM wrapper.
// Takes a valid/ready word stream and writes it to consecutive addresses
// from BASE_ADDR, with wrap at the top of the array. It can then read the
// region back and compare an additive checksum. All SRAM-facing outputs and
// the done pulse are registered: the combinational process computes their
// next value, and the state register process loads it.
module sram_loader_4096x32 #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          verify_en,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] checksum
);

    // DEPTH is expected to be 2**AW; it is only used for the length limit.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] BASE    = AW'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WFIN,
        READ,
        RFIN,
        DONE
    } state_t;

    // Checksums wrap modulo 2**DW by construction.
    function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        return a + b;
    endfunction

    state_t        state, state_n;
    logic [AW:0]   len_q, len_n;
    logic          verify_q, verify_n;
    logic [AW:0]   cnt, cnt_n;
    logic [AW:0]   rd_cnt, rd_cnt_n;
    logic [DW-1:0] wsum, wsum_n;
    logic [DW-1:0] rsum, rsum_n;
    logic          rd_vld_p1;
    logic          ce_n, we_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] din_n;
    logic          done_n, err_n;
    logic [DW-1:0] chk_n;

    assign s_ready = (state == WRITE);
    assign busy    = (state != IDLE);

    // Next state, next registered outputs and next counter/sum values.
    always_comb begin
        state_n  = state;
        len_n    = len_q;
        verify_n = verify_q;
        cnt_n    = cnt;
        rd_cnt_n = rd_cnt;
        wsum_n   = wsum;
        rsum_n   = rd_vld_p1 ? wrap_add(rsum, mem_dout) : rsum;
        ce_n     = 1'b0;
        we_n     = 1'b0;
        addr_n   = mem_addr;
        din_n    = mem_din;
        err_n    = err;
        chk_n    = checksum;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    err_n = 1'b0;
                    chk_n = '0;
                    if (len == '0) begin
                        state_n = DONE;
                    end else if (len > DEPTH_W) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else begin
                        state_n  = WRITE;
                        len_n    = len;
                        verify_n = verify_en;
                        cnt_n    = '0;
                        rd_cnt_n = '0;
                        wsum_n   = '0;
                        rsum_n   = '0;
                    end
                end
            end
            WRITE: begin
                if (s_valid) begin
                    ce_n   = 1'b1;
                    we_n   = 1'b1;
                    addr_n = BASE + cnt[AW-1:0];
                    din_n  = s_data;
                    cnt_n  = cnt + 1'b1;
                    wsum_n = wrap_add(wsum, s_data);
                    if (cnt == len_q - 1'b1) begin
                        state_n = WFIN;
                    end
                end
            end
            WFIN: begin
                // The first read is issued here so reads run back to back
                // from the first READ cycle.
                if (verify_q) begin
                    state_n  = READ;
                    ce_n     = 1'b1;
                    addr_n   = BASE;
                    rd_cnt_n = (AW+1)'(1);
                end else begin
                    state_n = DONE;
                end
            end
            READ: begin
                // rd_cnt counts reads already issued; once it reaches len the
                // last read is on the bus this cycle.
                if (rd_cnt == len_q) begin
                    state_n = RFIN;
                end else begin
                    ce_n     = 1'b1;
                    addr_n   = BASE + rd_cnt[AW-1:0];
                    rd_cnt_n = rd_cnt + 1'b1;
                end
            end
            RFIN: begin
                // The last read word arrives this cycle and is folded into
                // rsum_n, which feeds the comparison below.
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if ((state != IDLE) && (state != DONE) && (state_n == DONE)) begin
            chk_n = wsum_n;
            err_n = verify_q && (rsum_n != wsum_n);
        end

        done_n = (state_n == DONE);
    end

    // State, counters, sums and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            verify_q  <= 1'b0;
            cnt       <= '0;
            rd_cnt    <= '0;
            wsum      <= '0;
            rsum      <= '0;
            rd_vld_p1 <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
        end else begin
            state     <= state_n;
            len_q     <= len_n;
            verify_q  <= verify_n;
            cnt       <= cnt_n;
            rd_cnt    <= rd_cnt_n;
            wsum      <= wsum_n;
            rsum      <= rsum_n;
            // --- read data stage: mem_dout belongs to the read presented
            // one cycle earlier ---
            rd_vld_p1 <= mem_ce && !mem_we;
            mem_ce    <= ce_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_din   <= din_n;
            done      <= done_n;
            err       <= err_n;
            checksum  <= chk_n;
        end
    end

endmodule

// File: tb/tb_sram_loader_4096x32.sv
// Directed bench for sram_loader_4096x32. Inputs change and outputs are
// sampled on the falling clock edge. Instance dut uses BASE_ADDR=0 and has an
// SRAM model; instance dut_hi uses BASE_ADDR=4094 for the address-wrap case.
module tb_sram_loader_4096x32;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1;
    logic [12:0] len;
    logic        verify_en;
    logic        s_valid;
    logic [31:0] s_data;

    logic        s_ready0, ce0, we0, busy0, done0, err0;
    logic [11:0] addr0;
    logic [31:0] din0, dout0, chk0;

    logic        s_ready1, ce1, we1, busy1, done1, err1;
    logic [11:0] addr1;
    logic [31:0] din1, dout1, chk1;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram [0:4095];
    logic        corrupt;
    logic [11:0] corrupt_addr;
    int          ce_count = 0;

    assign dout1 = '0;

    sram_loader_4096x32 #(.AW(12), .DW(32), .DEPTH(4096), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start0), .len(len), .verify_en(verify_en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready0),
        .mem_ce(ce0), .mem_we(we0), .mem_addr(addr0), .mem_din(din0),
        .mem_dout(dout0), .busy(busy0), .done(done0), .err(err0),
        .checksum(chk0)
    );

    sram_loader_4096x32 #(.AW(12), .DW(32), .DEPTH(4096), .BASE_ADDR(4094)) dut_hi (
        .clk(clk), .rst(rst), .start(start1), .len(len), .verify_en(verify_en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
        .mem_ce(ce1), .mem_we(we1), .mem_addr(addr1), .mem_din(din1),
        .mem_dout(dout1), .busy(busy1), .done(done1), .err(err1),
        .checksum(chk1)
    );

    // SRAM model: registered read data, optional corruption of one address.
    always @(posedge clk) begin
        if (ce0 && we0) sram[addr0] <= din0;
        if (ce0 && !we0) dout0 <= (corrupt && addr0 == corrupt_addr) ? 32'h7 : sram[addr0];
        if (ce0) ce_count <= ce_count + 1;
    end

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; len = '0; verify_en = 1'b0;
        s_valid = 1'b0; s_data = '0; corrupt = 1'b0; corrupt_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready0, ce0, we0, addr0, din0, busy0, done0, err0, chk0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {s_ready0, ce0, we0, addr0, din0, busy0, done0, err0, chk0});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ready0, ce0, busy0, done0, err0, s_ready1, ce1, busy1} !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 00000000",
                     {s_ready0, ce0, busy0, done0, err0, s_ready1, ce1, busy1});
        end
    endtask

    task automatic test_write_noverify();
        logic [31:0] w [4];
        w = '{32'h1, 32'h2, 32'h3, 32'h4};
        @(negedge clk);
        start0 = 1'b1; len = 13'd4; verify_en = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if ({s_ready0, busy0} !== 2'b11) begin
            errors++;
            $display("FAIL t1_enter_write got %b want 11", {s_ready0, busy0});
        end
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = w[i];
            @(negedge clk);
            checks++;
            if ({ce0, we0, addr0, din0} !== {2'b11, 12'(i), w[i]}) begin
                errors++;
                $display("FAIL t1_write%0d got %h want %h", i,
                         {ce0, we0, addr0, din0}, {2'b11, 12'(i), w[i]});
            end
        end
        s_valid = 1'b0;
        checks++;
        if ({s_ready0, done0} !== 2'b00) begin
            errors++;
            $display("FAIL t1_wfin got %b want 00", {s_ready0, done0});
        end
        @(negedge clk);
        checks++;
        if ({done0, err0, ce0, chk0} !== {3'b100, 32'hA}) begin
            errors++;
            $display("FAIL t1_done got %h want %h", {done0, err0, ce0, chk0}, {3'b100, 32'hA});
        end
        @(negedge clk);
        checks++;
        if ({done0, busy0, chk0} !== {2'b00, 32'hA}) begin
            errors++;
            $display("FAIL t1_after_done got %h want %h", {done0, busy0, chk0}, {2'b00, 32'hA});
        end
    endtask

    task automatic test_verify(input logic bad);
        logic [31:0] w [4];
        w = '{32'h1, 32'h2, 32'h3, 32'h4};
        corrupt = bad; corrupt_addr = 12'd2;
        @(negedge clk);
        start0 = 1'b1; len = 13'd4; verify_en = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if ({s_ready0, err0, chk0} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL verify_start_clears got %h want %h", {s_ready0, err0, chk0}, {2'b10, 32'h0});
        end
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = w[i];
            @(negedge clk);
            checks++;
            if ({ce0, we0, addr0, din0} !== {2'b11, 12'(i), w[i]}) begin
                errors++;
                $display("FAIL verify_write%0d got %h want %h", i,
                         {ce0, we0, addr0, din0}, {2'b11, 12'(i), w[i]});
            end
        end
        s_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            checks++;
            if ({ce0, we0, addr0, done0} !== {2'b10, 12'(r), 1'b0}) begin
                errors++;
                $display("FAIL verify_read%0d got %h want %h", r,
                         {ce0, we0, addr0, done0}, {2'b10, 12'(r), 1'b0});
            end
        end
        @(negedge clk);
        checks++;
        if ({ce0, done0} !== 2'b00) begin
            errors++;
            $display("FAIL verify_rfin got %b want 00", {ce0, done0});
        end
        @(negedge clk);
        checks++;
        if ({done0, err0, chk0} !== {1'b1, bad, 32'hA}) begin
            errors++;
            $display("FAIL verify_done_bad%0b got %h want %h", bad,
                     {done0, err0, chk0}, {1'b1, bad, 32'hA});
        end
        @(negedge clk);
        checks++;
        if ({done0, err0} !== {1'b0, bad}) begin
            errors++;
            $display("FAIL verify_err_held got %b want %b", {done0, err0}, {1'b0, bad});
        end
        corrupt = 1'b0;
    endtask

    task automatic test_wrap_toggle();
        logic [31:0] d [4];
        logic [11:0] a [4];
        d = '{32'h10, 32'h20, 32'h30, 32'h40};
        a = '{12'd4094, 12'd4095, 12'd0, 12'd1};
        verify_en = 1'b0;
        @(negedge clk);
        start1 = 1'b1; len = 13'd4;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                checks++;
                if ((c - 1) % 2 == 0) begin
                    if ({ce1, we1, addr1, din1} !== {2'b11, a[(c-1)/2], d[(c-1)/2]}) begin
                        errors++;
                        $display("FAIL wrap_slot%0d got %h want %h", c - 1,
                                 {ce1, we1, addr1, din1}, {2'b11, a[(c-1)/2], d[(c-1)/2]});
                    end
                end else if (ce1 !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_idle_slot%0d mem_ce got %b want 0", c - 1, ce1);
                end
            end
            checks++;
            if (s_ready1 !== 1'b1) begin
                errors++;
                $display("FAIL wrap_ready_slot%0d got %b want 1", c, s_ready1);
            end
            s_valid = (c % 2 == 0);
            s_data  = (c % 2 == 0) ? d[c/2] : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if ({ce1, we1, addr1, din1, s_ready1} !== {2'b11, 12'd1, 32'h40, 1'b0}) begin
            errors++;
            $display("FAIL wrap_last got %h want %h", {ce1, we1, addr1, din1, s_ready1},
                     {2'b11, 12'd1, 32'h40, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({done1, err1, chk1} !== {2'b10, 32'hA0}) begin
            errors++;
            $display("FAIL wrap_done got %h want %h", {done1, err1, chk1}, {2'b10, 32'hA0});
        end
    endtask

    task automatic test_len_errors();
        int n0;
        n0 = ce_count;
        s_valid = 1'b1; s_data = 32'h1234;
        @(negedge clk);
        start0 = 1'b1; len = 13'd0;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if ({done0, err0, ce0, s_ready0} !== 4'b1000) begin
            errors++;
            $display("FAIL len0_done got %b want 1000", {done0, err0, ce0, s_ready0});
        end
        @(negedge clk);
        start0 = 1'b1; len = 13'd4097;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if ({done0, err0, ce0, s_ready0} !== 4'b1100) begin
            errors++;
            $display("FAIL len4097_done got %b want 1100", {done0, err0, ce0, s_ready0});
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if ({done0, err0, busy0} !== 3'b010) begin
            errors++;
            $display("FAIL len4097_after got %b want 010", {done0, err0, busy0});
        end
        checks++;
        if (ce_count !== n0) begin
            errors++;
            $display("FAIL len_err_no_access ce_cycles got %0d want %0d", ce_count, n0);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        start0 = 1'b1; len = 13'd8; verify_en = 1'b0;
        @(negedge clk);
        start0 = 1'b0; s_valid = 1'b1; s_data = 32'h100;
        @(negedge clk);
        s_data = 32'h200;
        @(negedge clk);
        checks++;
        if ({ce0, we0, addr0, din0} !== {2'b11, 12'd1, 32'h200}) begin
            errors++;
            $display("FAIL midop_write1 got %h want %h", {ce0, we0, addr0, din0},
                     {2'b11, 12'd1, 32'h200});
        end
        rst = 1'b1; s_data = 32'h300;
        @(negedge clk);
        checks++;
        if ({s_ready0, ce0, busy0, done0, err0} !== 5'b00000) begin
            errors++;
            $display("FAIL midop_reset got %b want 00000", {s_ready0, ce0, busy0, done0, err0});
        end
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        start0 = 1'b1; len = 13'd1;
        @(negedge clk);
        start0 = 1'b0; s_valid = 1'b1; s_data = 32'h55;
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if ({ce0, we0, addr0, din0, s_ready0} !== {2'b11, 12'd0, 32'h55, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_write got %h want %h", {ce0, we0, addr0, din0, s_ready0},
                     {2'b11, 12'd0, 32'h55, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({done0, err0, chk0} !== {2'b10, 32'h55}) begin
            errors++;
            $display("FAIL post_reset_done got %h want %h", {done0, err0, chk0}, {2'b10, 32'h55});
        end
    endtask

    initial begin
        test_reset();
        test_write_noverify();
        test_verify(1'b0);
        test_verify(1'b1);
        test_wrap_toggle();
        test_len_errors();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
